// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Forward-select encodings, the load result code and the memory-wait FSM states.
package pipeline_hazard_controller_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT
  } mem_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } dest_t;

  // The M stage is younger than W, so its result takes priority.
  function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                            input dest_t      m,
                                            input dest_t      w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (m.reg_write && (m.rd != 5'd0) && (m.rd == rs)) begin
      sel = FWD_MEM;
    end else if (w.reg_write && (w.rd != 5'd0) && (w.rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side bundle for the hazard controller: register indices and memory
// handshake flow in, stall/flush/forward controls flow out.
interface pipeline_hazard_controller_if;

  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic       RegWriteE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       mem_req_m;
  logic       mem_ready;

  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
           mem_req_m, mem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
           mem_req_m, mem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE
  );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall, flush and forwarding control for the 5-stage pipeline, with shadow M/W
// destination tracking, a data-memory wait/timeout FSM and saturating counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   hz,
  output logic [CNT_W-1:0]              stall_cycles,
  output logic [CNT_W-1:0]              flush_events,
  output logic                          mem_timeout
);

  localparam int                  WCNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0]   WAIT_MAX = WCNT_W'(TIMEOUT_CYCLES);

  logic mem_stall;
  logic lw_stall;
  logic stall_f;
  logic stall_e;
  logic flush_d;
  logic flush_e;
  logic branch_flush;

  dest_t m_d;
  dest_t m_q;
  dest_t w_d;
  dest_t w_q;

  mem_state_e        state_d;
  mem_state_e        state_q;
  logic [WCNT_W-1:0] wait_cnt_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              timeout_d;
  logic              timeout_q;

  // A memory wait freezes the whole pipe, so branch and load-use actions wait for it.
  always_comb begin
    mem_stall    = hz.mem_req_m & ~hz.mem_ready;
    lw_stall     = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != 5'd0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    stall_f      = 1'b0;
    stall_e      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    branch_flush = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_e = 1'b1;
      end else begin
        stall_f      = lw_stall;
        flush_d      = hz.PCSrcE;
        flush_e      = lw_stall | hz.PCSrcE;
        branch_flush = hz.PCSrcE;
      end
    end
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_f;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_e;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.ForwardAE = reset ? FWD_RF : fwd_select(hz.Rs1E, m_q, w_q);
  assign hz.ForwardBE = reset ? FWD_RF : fwd_select(hz.Rs2E, m_q, w_q);

  // Flushed bubbles still advance here; they arrive next cycle as RegWriteE=0.
  always_comb begin
    m_d = m_q;
    w_d = w_q;
    if (!mem_stall) begin
      m_d.rd        = hz.RdE;
      m_d.reg_write = hz.RegWriteE;
      w_d           = m_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (mem_stall) begin
          state_d    = WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (hz.mem_ready || !hz.mem_req_m) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end else begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q        <= '0;
      w_q        <= '0;
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      m_q        <= m_d;
      w_q        <= w_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_f),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_flush),
    .count (flush_events)
  );

endmodule
